// File: rtl/ttt_pkg.sv
// Shared tic-tac-toe types: cell one-hot vector, conditioner states and cell bit constants.
package ttt_pkg;

    localparam int unsigned NUM_CELLS = 9;

    typedef logic [NUM_CELLS-1:0] cell_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ARMED = 2'd1,
        HOLD  = 2'd2
    } cond_state_e;

    localparam cell_t CELL1 = 9'h001;
    localparam cell_t CELL2 = 9'h002;
    localparam cell_t CELL3 = 9'h004;
    localparam cell_t CELL4 = 9'h008;
    localparam cell_t CELL5 = 9'h010;
    localparam cell_t CELL6 = 9'h020;
    localparam cell_t CELL7 = 9'h040;
    localparam cell_t CELL8 = 9'h080;
    localparam cell_t CELL9 = 9'h100;

endpackage

// File: rtl/debounce_channel.sv
// One debounced input: optional 2-flop synchronizer (MOVE_COND_SYNC_EN), run-length
// counter, debounced level and a registered one-cycle rise pulse.
module debounce_channel #(
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic rise
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);

    logic             sample;
    logic             level_q, level_d;
    logic             rise_q, rise_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

`ifdef MOVE_COND_SYNC_EN
    logic [1:0] sync_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], raw};
        end
    end

    assign sample = sync_q[1];
`else
    assign sample = raw;
`endif

    // Counter holds (differing samples seen - 1); the limit sample flips the level.
    always_comb begin
        level_d = level_q;
        rise_d  = 1'b0;
        cnt_d   = '0;
        if (sample != level_q) begin
            if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                level_d = sample;
                rise_d  = sample;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            level_q <= level_d;
            rise_q  <= rise_d;
            cnt_q   <= cnt_d;
        end
    end

    assign rise = rise_q;

endmodule

// File: rtl/move_input_conditioner.sv
// Debounces 9 cell switches plus play/pc, latches one selected cell and issues move strobes.
// Optional input synchronizers are enabled by defining MOVE_COND_SYNC_EN.
module move_input_conditioner
    import ttt_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned HOLD_CYCLES     = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_CELLS-1:0] btn_raw,
    input  logic                 play_raw,
    input  logic                 pc_raw,
    output logic [NUM_CELLS-1:0] button,
    output logic                 play,
    output logic                 pc,
    output logic                 cell_valid,
    output logic                 err_multi,
    output logic                 err_no_cell,
    output logic                 err_conflict
);

    localparam int unsigned HOLD_W = 8;

    cell_t             cell_rise;
    logic              play_rise, pc_rise;
    logic              one_cell, multi_cell;

    cond_state_e       state_q, state_d;
    cell_t             button_q, button_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              play_q, play_d, pc_q, pc_d, valid_q;
    logic              em_q, em_d, enc_q, enc_d, ec_q, ec_d;

    for (genvar i = 0; i < NUM_CELLS; i++) begin : g_cell
        debounce_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_db (
            .clk  (clk),
            .reset(reset),
            .raw  (btn_raw[i]),
            .rise (cell_rise[i])
        );
    end

    debounce_channel #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db_play (
        .clk  (clk),
        .reset(reset),
        .raw  (play_raw),
        .rise (play_rise)
    );

    debounce_channel #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db_pc (
        .clk  (clk),
        .reset(reset),
        .raw  (pc_raw),
        .rise (pc_rise)
    );

    // x & (x-1) clears the lowest set bit: non-zero means two or more edges.
    assign multi_cell = (cell_rise & (cell_rise - cell_t'(1))) != '0;
    assign one_cell   = (cell_rise != '0) && !multi_cell;

    always_comb begin
        state_d  = state_q;
        button_d = button_q;
        hold_d   = hold_q;
        play_d   = 1'b0;
        pc_d     = 1'b0;
        em_d     = 1'b0;
        enc_d    = 1'b0;
        ec_d     = 1'b0;
        unique case (state_q)
            EMPTY: begin
                enc_d = play_rise | pc_rise;
                if (one_cell) begin
                    button_d = cell_rise;
                    state_d  = ARMED;
                end else if (multi_cell) begin
                    em_d = 1'b1;
                end
            end
            ARMED: begin
                // A move edge wins over any cell edge arriving in the same cycle.
                if (play_rise && pc_rise) begin
                    ec_d = 1'b1;
                end else if (play_rise || pc_rise) begin
                    play_d  = play_rise;
                    pc_d    = pc_rise;
                    hold_d  = '0;
                    state_d = HOLD;
                end else if (one_cell) begin
                    button_d = cell_rise;
                end else if (multi_cell) begin
                    em_d = 1'b1;
                end
            end
            HOLD: begin
                if (hold_q == HOLD_W'(HOLD_CYCLES)) begin
                    button_d = '0;
                    hold_d   = '0;
                    state_d  = EMPTY;
                end else begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
            default: begin
                button_d = '0;
                hold_d   = '0;
                state_d  = EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= EMPTY;
            button_q <= '0;
            hold_q   <= '0;
            play_q   <= 1'b0;
            pc_q     <= 1'b0;
            valid_q  <= 1'b0;
            em_q     <= 1'b0;
            enc_q    <= 1'b0;
            ec_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            button_q <= button_d;
            hold_q   <= hold_d;
            play_q   <= play_d;
            pc_q     <= pc_d;
            valid_q  <= |button_d;
            em_q     <= em_d;
            enc_q    <= enc_d;
            ec_q     <= ec_d;
        end
    end

    assign button       = button_q;
    assign play         = play_q;
    assign pc           = pc_q;
    assign cell_valid   = valid_q;
    assign err_multi    = em_q;
    assign err_no_cell  = enc_q;
    assign err_conflict = ec_q;

endmodule

// File: tb/tb_move_input_conditioner.sv
// Directed plus random bench for move_input_conditioner with a cycle-level behavioural model.
module tb_move_input_conditioner;

    localparam int DB = 4;
    localparam int HC = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic [8:0] btn_raw;
    logic       play_raw, pc_raw;
    logic [8:0] button;
    logic       play, pc, cell_valid, err_multi, err_no_cell, err_conflict;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: per-channel debounced level, length of current disagreeing run, pending rise.
    int         lvl [11];
    int         run [11];
    bit         rise_r [11];
    int         m_state;      // 0 empty, 1 armed, 2 hold
    int         hold_left;
    logic [8:0] m_button;
    logic       m_play, m_pc, m_cv, m_em, m_enc, m_ec;

    move_input_conditioner #(
        .DEBOUNCE_CYCLES(DB),
        .HOLD_CYCLES    (HC)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .btn_raw     (btn_raw),
        .play_raw    (play_raw),
        .pc_raw      (pc_raw),
        .button      (button),
        .play        (play),
        .pc          (pc),
        .cell_valid  (cell_valid),
        .err_multi   (err_multi),
        .err_no_cell (err_no_cell),
        .err_conflict(err_conflict)
    );

    always #5 clk = ~clk;

    function automatic void model_edge(input logic rst, input logic [10:0] smp);
        logic [8:0] cells;
        int         nc;
        logic       pl, pr;
        if (rst) begin
            for (int i = 0; i < 11; i++) begin
                lvl[i] = 0; run[i] = 0; rise_r[i] = 0;
            end
            m_state = 0; hold_left = 0; m_button = '0;
            {m_play, m_pc, m_cv, m_em, m_enc, m_ec} = '0;
            return;
        end
        for (int i = 0; i < 9; i++) cells[i] = rise_r[i];
        nc = $countones(cells);
        pl = rise_r[9];
        pr = rise_r[10];
        {m_play, m_pc, m_em, m_enc, m_ec} = '0;
        if (m_state == 0) begin
            m_enc = pl | pr;
            if (nc == 1) begin
                m_button = cells; m_state = 1;
            end else if (nc > 1) begin
                m_em = 1;
            end
        end else if (m_state == 1) begin
            if (pl && pr) m_ec = 1;
            else if (pl || pr) begin
                m_play = pl; m_pc = pr; m_state = 2; hold_left = HC;
            end else if (nc == 1) m_button = cells;
            else if (nc > 1) m_em = 1;
        end else begin
            if (hold_left == 0) begin
                m_button = '0; m_state = 0;
            end else begin
                hold_left--;
            end
        end
        m_cv = (m_button != 0);
        // Debounce: level flips once DB consecutive samples disagree with it.
        for (int i = 0; i < 11; i++) begin
            rise_r[i] = 0;
            if (int'(smp[i]) != lvl[i]) begin
                run[i]++;
                if (run[i] == DB) begin
                    lvl[i] = int'(smp[i]); run[i] = 0; rise_r[i] = smp[i];
                end
            end else begin
                run[i] = 0;
            end
        end
    endfunction

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step(input logic r, input logic [8:0] b, input logic p, input logic c);
        logic [14:0] obs, exp;
        reset = r; btn_raw = b; play_raw = p; pc_raw = c;
        @(posedge clk);
        model_edge(r, {c, p, b});
        #1;
        obs = {button, play, pc, cell_valid, err_multi, err_no_cell, err_conflict};
        exp = {m_button, m_play, m_pc, m_cv, m_em, m_enc, m_ec};
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL model_cycle t=%0t: observed %h expected %h", $time, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 9'h000, 1'b0, 1'b0);
    endtask

    task automatic press(input logic [8:0] b, input logic p, input logic c, input int n);
        for (int i = 0; i < n; i++) step(1'b0, b, p, c);
    endtask

    initial begin
        int         plays;
        logic       noisy;
        logic [8:0] rb;
        logic       rp, rc;
        int         len, cyc;

        // Reset state
        step(1'b1, 9'h000, 1'b0, 1'b0);
        step(1'b1, 9'h000, 1'b0, 1'b0);
        chk("reset_button", 16'(button), 16'h0000);
        chk("reset_flags", 16'({play, pc, cell_valid, err_multi, err_no_cell, err_conflict}), 16'h0);
        idle(2);

        // Cell 5 then play, with the hold window
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 9'h010, 1'b0, 1'b0);
            if (i == 3) chk("cell5_before_latch", 16'(button), 16'h0000);
            if (i == 4) begin
                chk("cell5_latched", 16'(button), 16'h0010);
                chk("cell5_valid", 16'(cell_valid), 16'h1);
            end
        end
        plays = 0;
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 9'h010, 1'b1, 1'b0);
            plays += int'(play);
            if (i == 4) chk("play_pulse", 16'(play), 16'h1);
            if (i == 6) chk("hold_button", 16'(button), 16'h0010);
            if (i == 7) chk("hold_cleared", 16'({button, cell_valid}), 16'h0000);
        end
        chk("play_once", 16'(plays), 16'h1);
        idle(6);

        // Bouncing cell 3 never settles
        noisy = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step(1'b0, ((i / 2) % 2 == 1) ? 9'h004 : 9'h000, 1'b0, 1'b0);
            noisy |= (button != 0) | play | pc | err_multi | err_no_cell | err_conflict;
        end
        chk("bounce_quiet", 16'(noisy), 16'h0);
        idle(6);

        // Cells 1 and 9 together, then cell 3 alone
        press(9'h101, 1'b0, 1'b0, 5);
        chk("multi_err", 16'({err_multi, button}), 16'h0200);
        step(1'b0, 9'h101, 1'b0, 1'b0);
        chk("multi_err_one_cycle", 16'(err_multi), 16'h0);
        idle(6);
        press(9'h004, 1'b0, 1'b0, 5);
        chk("cell3_latched", 16'(button), 16'h0004);
        idle(6);

        // Cell 4 replaces cell 3, then play and pc together
        press(9'h008, 1'b0, 1'b0, 5);
        chk("cell4_latched", 16'(button), 16'h0008);
        idle(6);
        press(9'h000, 1'b1, 1'b1, 5);
        chk("conflict_err", 16'({err_conflict, play, pc}), 16'h4);
        chk("conflict_keeps_cell", 16'(button), 16'h0008);
        step(1'b0, 9'h000, 1'b1, 1'b1);
        chk("conflict_one_cycle", 16'(err_conflict), 16'h0);
        idle(6);
        press(9'h000, 1'b1, 1'b0, 5);
        chk("play_from_cell4", 16'({play, button}), 16'h0208);
        idle(6);
        chk("back_to_empty", 16'(button), 16'h0000);

        // Pc with nothing latched
        press(9'h000, 1'b0, 1'b1, 5);
        chk("no_cell_err", 16'({err_no_cell, pc}), 16'h2);
        idle(6);

        // Reset while holding
        press(9'h020, 1'b0, 1'b0, 5);
        chk("cell6_latched", 16'(button), 16'h0020);
        idle(6);
        press(9'h000, 1'b1, 1'b0, 5);
        chk("play_before_reset", 16'(play), 16'h1);
        step(1'b1, 9'h000, 1'b0, 1'b0);
        chk("reset_in_hold", 16'({button, play, pc, cell_valid, err_multi, err_no_cell, err_conflict}),
            16'h0000);
        idle(3);
        chk("empty_after_reset", 16'(button), 16'h0000);

        // Change of mind: cell 2 then cell 7, then pc
        press(9'h002, 1'b0, 1'b0, 5);
        chk("cell2_latched", 16'(button), 16'h0002);
        idle(6);
        press(9'h040, 1'b0, 1'b0, 5);
        chk("cell7_replaces", 16'(button), 16'h0040);
        idle(6);
        press(9'h000, 1'b0, 1'b1, 5);
        chk("pc_with_cell7", 16'({pc, button}), 16'h0240);
        idle(6);

        // Random held inputs, checked each cycle by the model
        cyc = 0;
        while (cyc < 1500) begin
            for (int i = 0; i < 9; i++) rb[i] = ($urandom_range(0, 5) == 0);
            rp  = ($urandom_range(0, 4) == 0);
            rc  = ($urandom_range(0, 4) == 0);
            len = $urandom_range(1, 9);
            for (int k = 0; k < len; k++) begin
                step(($urandom_range(0, 99) == 0), rb, rp, rc);
                cyc++;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
